// File: rtl/ksa_seq_pkg.sv
// ---------------------------------------------------------------------------
// ksa_seq_pkg
// Shared definitions for the wide-add sequencer around a 4-bit adder core:
//   seq_state_t : sequencer FSM states
//   SLICE       : width of the external adder core
//   clog2()     : counter width helper (never returns less than 1 bit)
// ---------------------------------------------------------------------------
package ksa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int SLICE = 4;

    // Bits needed to hold values 0..value-1; clamped to 1 so that a
    // degenerate count of 1 still yields a legal vector width.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ksa_lat_timer.sv
// ---------------------------------------------------------------------------
// ksa_lat_timer
// Loadable down-counter with zero flag. Counts down once per clock until it
// reaches zero, then holds. A load takes priority over counting.
// Ports:
//   clk      : system clock
//   rst_n    : synchronous active-low reset (count cleared to zero)
//   load     : load load_val this cycle
//   load_val : value to load
//   zero     : count is zero
// ---------------------------------------------------------------------------
module ksa_lat_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_r;

    // Count register: load, else decrement toward zero, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/ksa4_wide_add_seq.sv
// ---------------------------------------------------------------------------
// ksa4_wide_add_seq
// Performs a WIDTH-bit addition by feeding one shared, pipelined SLICE-bit
// adder core slice by slice (LSB first). Each slice is held on the core
// inputs for ADDER_LAT edges, then its sum is captured and its carry-out is
// forwarded straight into the next slice's carry-in.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake (ready only when idle)
//   in_a, in_b, in_cin    : operands and carry into slice 0
//   out_valid/out_ready   : result handshake
//   out_sum, out_cout     : WIDTH-bit sum and final carry
//   add_a, add_b, add_cin : registered inputs to the external adder core
//   add_valid             : one-cycle pulse when a new slice is applied
//   add_s, add_cout       : adder core sum and carry outputs
// ---------------------------------------------------------------------------
module ksa4_wide_add_seq #(
    parameter int WIDTH     = 16,
    parameter int SLICE     = ksa_seq_pkg::SLICE,
    parameter int ADDER_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [SLICE-1:0] add_a,
    output logic [SLICE-1:0] add_b,
    output logic             add_cin,
    output logic             add_valid,
    input  logic [SLICE-1:0] add_s,
    input  logic             add_cout
);

    import ksa_seq_pkg::*;

    localparam int NSLICE = WIDTH / SLICE;
    localparam int TW     = clog2(ADDER_LAT);
    localparam int IW     = clog2(NSLICE);

    localparam logic [TW-1:0] TIMER_LOAD = TW'(ADDER_LAT - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NSLICE - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);

    seq_state_t state_r;
    seq_state_t state_next_s;

    logic [WIDTH-1:0]       a_r;          // operand A bits not yet issued
    logic [WIDTH-1:0]       b_r;          // operand B bits not yet issued
    logic [WIDTH-1:0]       sum_r;        // slice sums, shifted in from the top
    logic [IW-1:0]          idx_r;
    logic                   accept_s;
    logic                   capture_s;
    logic                   timer_load_s;
    logic                   timer_zero_s;
    logic                   last_slice_s;
    logic [WIDTH+SLICE-1:0] sum_cat_s;
    logic [WIDTH-1:0]       sum_shift_s;

    // Each captured slice enters at the MSB end; after NSLICE captures the
    // first slice has reached bit 0, so no variable part-select is needed.
    assign sum_cat_s    = {add_s, sum_r};
    assign sum_shift_s  = sum_cat_s[WIDTH+SLICE-1:SLICE];
    assign last_slice_s = (idx_r == LAST_IDX);

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);

    ksa_lat_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (TIMER_LOAD),
        .zero     (timer_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and datapath control strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        timer_load_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                timer_load_s = 1'b1;
                state_next_s = WAIT;
            end
            WAIT: begin
                if (timer_zero_s) begin
                    capture_s = 1'b1;
                    if (last_slice_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = ISSUE;
                    end
                end else begin
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: slice loading, carry bypass, sum assembly and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            idx_r     <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            add_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else begin
            add_valid <= 1'b0;
            if (accept_s) begin
                add_a     <= in_a[SLICE-1:0];
                add_b     <= in_b[SLICE-1:0];
                add_cin   <= in_cin;
                a_r       <= in_a >> SLICE;
                b_r       <= in_b >> SLICE;
                idx_r     <= '0;
                sum_r     <= '0;
                add_valid <= 1'b1;
            end else if (capture_s) begin
                sum_r <= sum_shift_s;
                if (!last_slice_s) begin
                    // Carry-out feeds the next slice on the same edge it is captured.
                    idx_r     <= idx_r + IDX_ONE;
                    add_a     <= a_r[SLICE-1:0];
                    add_b     <= b_r[SLICE-1:0];
                    add_cin   <= add_cout;
                    a_r       <= a_r >> SLICE;
                    b_r       <= b_r >> SLICE;
                    add_valid <= 1'b1;
                end else begin
                    out_sum  <= sum_shift_s;
                    out_cout <= add_cout;
                end
            end else begin
                sum_r <= sum_r;
            end
        end
    end

endmodule

// File: tb/tb_ksa4_wide_add_seq.sv
// ---------------------------------------------------------------------------
// tb_ksa4_wide_add_seq
// Self-checking bench: a behavioural 4-bit core with a fixed edge delay is
// wired to add_*, and results are compared against plain integer addition.
// ---------------------------------------------------------------------------
module tb_ksa4_wide_add_seq;

    localparam int WIDTH     = 16;
    localparam int SLICE     = 4;
    localparam int ADDER_LAT = 4;
    localparam int NSLICE    = WIDTH / SLICE;
    localparam int LATENCY   = NSLICE * (ADDER_LAT + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [SLICE-1:0] add_a;
    logic [SLICE-1:0] add_b;
    logic             add_cin;
    logic             add_valid;
    logic [SLICE-1:0] add_s;
    logic             add_cout;

    int checks = 0;
    int errors = 0;

    bit cin_log[$];

    ksa4_wide_add_seq #(
        .WIDTH     (WIDTH),
        .SLICE     (SLICE),
        .ADDER_LAT (ADDER_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_valid (add_valid),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    always #5 clk = ~clk;

    // Behavioural adder core: result appears ADDER_LAT edges after inputs change.
    logic [SLICE:0] core_pipe [ADDER_LAT];
    always @(posedge clk) begin
        core_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{SLICE{1'b0}}, add_cin};
        for (int i = 1; i < ADDER_LAT; i++) begin
            core_pipe[i] <= core_pipe[i-1];
        end
    end
    assign add_s    = core_pipe[ADDER_LAT-1][SLICE-1:0];
    assign add_cout = core_pipe[ADDER_LAT-1][SLICE];

    // Log carry-in of every issued slice.
    always @(negedge clk) begin
        if (add_valid) begin
            cin_log.push_back(add_cin);
        end
    end

    // Core inputs must only change on cycles that announce a new slice.
    logic             rst_seen = 1'b1;
    bit               have_prev = 1'b0;
    logic [2*SLICE:0] prev_in;
    always @(posedge clk) begin
        rst_seen <= !rst_n;
    end
    always @(negedge clk) begin
        if (rst_seen) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev && !add_valid) begin
                checks++;
                if ({add_a, add_b, add_cin} !== prev_in) begin
                    errors++;
                    $display("FAIL add_stable: add_a/b/cin=%h required %h", {add_a, add_b, add_cin}, prev_in);
                end
            end
            prev_in   = {add_a, add_b, add_cin};
            have_prev = 1'b1;
        end
    end

    // Present operands and let the next edge accept them.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready: in_ready=%b required 1", in_ready);
        end
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        cin_log.delete();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for the result, compare against the reference, optionally complete the handshake.
    task automatic finish_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                             input string name, input bit chk_lat, input bit handshake);
        logic [WIDTH:0] expv;
        int lat;
        expv = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        lat  = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b required 1 within 200 cycles", name, out_valid);
            return;
        end
        if (chk_lat) begin
            checks++;
            if (lat != LATENCY) begin
                errors++;
                $display("FAIL %s_latency: %0d edges required %0d", name, lat, LATENCY);
            end
        end
        checks++;
        if ({out_cout, out_sum} !== expv) begin
            errors++;
            $display("FAIL %s_result: cout/sum=%b/%h required %b/%h", name, out_cout, out_sum, expv[WIDTH], expv[WIDTH-1:0]);
        end
        checks++;
        if (cin_log.size() != NSLICE) begin
            errors++;
            $display("FAIL %s_slices: %0d slices issued required %0d", name, cin_log.size(), NSLICE);
        end
        if (handshake) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_release: out_valid/in_ready=%b/%b required 0/1", name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready/out_valid/add_valid=%b/%b/%b required 1/0/0", in_ready, out_valid, add_valid);
        end
        checks++;
        if (add_a !== 4'h0 || add_b !== 4'h0 || add_cin !== 1'b0 || out_sum !== 16'h0000 || out_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: add_a/b/cin=%h/%h/%b out=%b/%h required zeros", add_a, add_b, add_cin, out_cout, out_sum);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        start_op(16'h1234, 16'h4321, 1'b0);
        finish_op(16'h1234, 16'h4321, 1'b0, "basic", 1'b1, 1'b1);
    endtask

    task automatic test_carry_chain();
        bit exp_cin[$];
        exp_cin = '{1'b0, 1'b1, 1'b1, 1'b1};
        start_op(16'hFFFF, 16'h0001, 1'b0);
        finish_op(16'hFFFF, 16'h0001, 1'b0, "carry_chain", 1'b1, 1'b0);
        checks++;
        if (cin_log != exp_cin) begin
            errors++;
            $display("FAIL carry_chain_cin: slice cins=%p required %p", cin_log, exp_cin);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_boundaries();
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        finish_op(16'hFFFF, 16'hFFFF, 1'b1, "all_ones", 1'b0, 1'b1);
        start_op(16'h0000, 16'h0000, 1'b1);
        finish_op(16'h0000, 16'h0000, 1'b1, "cin_only", 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
        for (int n = 0; n < 10; n++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            c = 1'($urandom_range(0, 1));
            start_op(a, b, c);
            finish_op(a, b, c, "random", 1'b1, 1'b1);
        end
    endtask

    task automatic test_done_hold();
        logic [WIDTH:0] expv;
        expv = {1'b0, 16'hA5A5} + {1'b0, 16'h1234};
        start_op(16'hA5A5, 16'h1234, 1'b0);
        finish_op(16'hA5A5, 16'h1234, 1'b0, "hold", 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 2);
            in_a     = 16'h0F0F;
            in_b     = 16'h0101;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || add_valid !== 1'b0 || {out_cout, out_sum} !== expv) begin
                errors++;
                $display("FAIL hold_cycle%0d: out_valid/in_ready/add_valid=%b/%b/%b sum=%h required 1/0/0 %h",
                         k, out_valid, in_ready, add_valid, out_sum, expv[WIDTH-1:0]);
            end
        end
        // Result release and a new request together: only the release completes.
        in_valid  = 1'b1;
        in_a      = 16'h0F0F;
        in_b      = 16'h0101;
        in_cin    = 1'b1;
        out_ready = 1'b1;
        cin_log.delete();
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_simul: out_valid/in_ready/add_valid=%b/%b/%b required 0/1/0", out_valid, in_ready, add_valid);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        finish_op(16'h0F0F, 16'h0101, 1'b1, "after_hold", 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        int guard;
        start_op(16'hBEEF, 16'h1357, 1'b1);
        guard = 0;
        while (cin_log.size() < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (cin_log.size() < 3) begin
            errors++;
            $display("FAIL midrst_slice2: %0d slices issued required 3", cin_log.size());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_valid !== 1'b0 || add_a !== 4'h0 || out_sum !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_idle: in_ready/out_valid/add_valid=%b/%b/%b add_a=%h out_sum=%h required 1/0/0 0 0000",
                     in_ready, out_valid, add_valid, add_a, out_sum);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_result: out_valid=%b required 0 at cycle %0d", out_valid, k);
            end
        end
        start_op(16'h00FF, 16'h0001, 1'b0);
        finish_op(16'h00FF, 16'h0001, 1'b0, "post_reset", 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_chain();
        test_boundaries();
        test_random();
        test_done_hold();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
